dffrf_wport_arbiter: RTL and testbench
======================================

Name: dffrf_wport_arbiter

Overview:
- Shares the single write port of the 2R1W DFF register file among NREQ independent write requesters, using round-robin arbitration and valid/ready handshakes.
- Registers the winning write into a one-entry commit stage that drives the register file's WE/RW/DW.
- Forwards the in-flight write to both read ports so readers never see a stale value during the commit cycle.
- Sits between the register file and its writers (e.g. ALU and load writeback units).

Parameters:
- WSIZE, 32, data word width; must match the register file.
- NREQ, 4, number of write requesters (2..8).
- R0_ZERO, 1, when 1, register 0 is hardwired to zero: writes to it are accepted and dropped, reads of it are never forwarded.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  NREQ  per-requester write request.
- REQ_READY  out  NREQ  per-requester grant; at most one bit high.
- REQ_RW  in  NREQ*5  destination register per requester; requester i uses bits [5i+4:5i].
- REQ_DW  in  NREQ*WSIZE  write data per requester; requester i uses slice i.
- HOLD  in  1  when 1, no grants are issued (all REQ_READY low).
- RA, RB  in  5  read addresses from consumers.
- DA, DB  out  WSIZE  read data to consumers, bypass-corrected.
- RF_RA, RF_RB  out  5  to the register file; equal to RA, RB (combinational pass-through).
- RF_DA, RF_DB  in  WSIZE  read data from the register file.
- RF_RW  out  5  commit-stage destination register.
- RF_DW  out  WSIZE  commit-stage write data.
- RF_WE  out  1  commit-stage write enable.
- GNT_ID  out  clog2(NREQ)  index of the current grant; valid only when |REQ_READY.

Behaviour:
- Reset (RST_N low, asynchronous):
  - RF_WE=0, RF_RW=0, RF_DW=0.
  - Round-robin pointer PTR=0.
  - REQ_READY forced to all 0 for as long as RST_N is low.
- Arbitration (combinational):
  - Scan requesters PTR, PTR+1, ... (mod NREQ); the first with REQ_VALID=1 wins.
  - REQ_READY[win]=1 and GNT_ID=win, unless HOLD=1 or no requester is valid.
  - REQ_READY may depend combinationally on REQ_VALID; REQ_VALID must not depend on REQ_READY.
- Acceptance: a transfer occurs on a rising edge where REQ_VALID[i]&REQ_READY[i]=1. A requester holds RW/DW stable while valid and not yet accepted.
- Pointer:
  - On acceptance by requester i, PTR <= (i+1) mod NREQ.
  - Otherwise PTR holds.
  - Consequence: a continuously valid requester waits at most NREQ-1 grants.
- Commit stage, one entry, updated every edge:
  - On acceptance of a write with RW!=0 or R0_ZERO=0: RF_WE<=1, RF_RW<=RW, RF_DW<=DW.
  - On acceptance of a write with RW=0 and R0_ZERO=1: RF_WE<=0. The handshake still completes.
  - With no acceptance: RF_WE<=0; RF_RW and RF_DW hold their last values.
- Write latency:
  - Data is accepted at edge N, presented on RF_* during cycle N..N+1, and written into the register file at edge N+1.
  - Throughput is one write per cycle.
- Bypass:
  - DA = (RF_WE && RF_RW==RA && !(R0_ZERO && RA==0)) ? RF_DW : RF_DA. DB is the same using RB.
  - Both ports may forward in the same cycle.
  - After edge N+1 the register file itself holds the value and no bypass is needed.
- Back-to-back writes to the same register: the commit stage holds only the newest value, so reads always return the most recent accepted write.
- HOLD:
  - Blocks new grants only; an already-committed write still completes at the next edge.
  - PTR is unchanged while HOLD=1.
- Reset mid-operation: a pending commit is discarded (RF_WE=0 immediately). No partial write reaches the register file unless the edge preceded reset assertion.
- GNT_ID is 0 when there is no grant.

Test Plan:
- Reset then idle: RST_N=0 with REQ_VALID=4'hF -> REQ_READY=0, RF_WE=0. Release reset, REQ_VALID=4'hF -> grants to 0,1,2,3,0 on consecutive cycles; RF_WE=1 from the second cycle.
- Single write plus bypass: req2 writes R5=32'hDEADBEEF, RA=5 in the cycle after acceptance -> RF_WE=1, RF_RW=5, DA=32'hDEADBEEF while RF_DA is still old. Next cycle RF_WE=0 and DA comes from RF_DA (=32'hDEADBEEF from the model).
- R0 suppression (R0_ZERO=1): req1 writes R0=32'h12345678 -> REQ_READY[1]=1, RF_WE stays 0. RA=0 -> DA=RF_DA=0, no forward.
- Fairness: req0 and req3 continuously valid, PTR=0 -> grants alternate 0,3,0,3. Requester 1 raises valid after a grant to 0 -> served within 2 grants.
- HOLD: HOLD=1 for 3 cycles with req1 valid -> REQ_READY=0 and PTR unchanged. A write accepted in the cycle before HOLD still commits. HOLD=0 -> req1 is granted the same cycle.
- Async reset during commit: accept R7=32'hA5A5A5A5, assert RST_N=0 mid-cycle -> RF_WE drops immediately, R7 is not written, PTR=0 after release.

Source files
------------

// File: rtl/dffrf_wport_arbiter.sv
// Round-robin arbiter sharing the single write port of a 2R1W DFF register file.
// The winning write is registered in a one-entry commit stage and forwarded to both read ports.
module dffrf_wport_arbiter #(
    parameter int WSIZE   = 32,
    parameter int NREQ    = 4,
    parameter int R0_ZERO = 1,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NREQ-1:0]       REQ_VALID,
    output logic [NREQ-1:0]       REQ_READY,
    input  logic [NREQ*5-1:0]     REQ_RW,
    input  logic [NREQ*WSIZE-1:0] REQ_DW,
    input  logic                  HOLD,
    input  logic [4:0]            RA,
    input  logic [4:0]            RB,
    output logic [WSIZE-1:0]      DA,
    output logic [WSIZE-1:0]      DB,
    output logic [4:0]            RF_RA,
    output logic [4:0]            RF_RB,
    input  logic [WSIZE-1:0]      RF_DA,
    input  logic [WSIZE-1:0]      RF_DB,
    output logic [4:0]            RF_RW,
    output logic [WSIZE-1:0]      RF_DW,
    output logic                  RF_WE,
    output logic [GW-1:0]         GNT_ID
);

    logic [GW-1:0]    ptr_q, ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_rw_q, rf_rw_d;
    logic [WSIZE-1:0] rf_dw_q, rf_dw_d;

    logic [GW-1:0]    win;
    logic             found;
    logic             grant;
    int               cand;
    logic [4:0]       sel_rw;
    logic [WSIZE-1:0] sel_dw;
    logic             drop_r0;

    // Scan from the pointer, wrapping; the first valid requester wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && REQ_VALID[cand[GW-1:0]]) begin
                found = 1'b1;
                win   = cand[GW-1:0];
            end
        end
    end

    // Grants are suppressed while in reset so nothing handshakes with a clearing stage.
    assign grant = found && !HOLD && RST_N;

    always_comb begin
        REQ_READY = '0;
        sel_rw    = '0;
        sel_dw    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == GW'(i)) begin
                REQ_READY[i] = grant;
                sel_rw       = REQ_RW[i*5 +: 5];
                sel_dw       = REQ_DW[i*WSIZE +: WSIZE];
            end
        end
    end

    assign GNT_ID = grant ? win : '0;

    // Writes to a hardwired-zero R0 still complete the handshake but never reach the file.
    always_comb begin
        drop_r0 = (R0_ZERO != 0) && (sel_rw == 5'd0);
        ptr_d   = ptr_q;
        if (grant) begin
            ptr_d = (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
        end
        rf_we_d = grant && !drop_r0;
        rf_rw_d = rf_we_d ? sel_rw : rf_rw_q;
        rf_dw_d = rf_we_d ? sel_dw : rf_dw_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q   <= '0;
            rf_we_q <= 1'b0;
            rf_rw_q <= '0;
            rf_dw_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= rf_we_d;
            rf_rw_q <= rf_rw_d;
            rf_dw_q <= rf_dw_d;
        end
    end

    assign RF_WE = rf_we_q;
    assign RF_RW = rf_rw_q;
    assign RF_DW = rf_dw_q;
    assign RF_RA = RA;
    assign RF_RB = RB;

    // The in-flight write lands at the next edge, so readers take it from the commit stage.
    assign DA = (rf_we_q && rf_rw_q == RA && !((R0_ZERO != 0) && RA == 5'd0)) ? rf_dw_q : RF_DA;
    assign DB = (rf_we_q && rf_rw_q == RB && !((R0_ZERO != 0) && RB == 5'd0)) ? rf_dw_q : RF_DB;

endmodule

// File: tb/tb_dffrf_wport_arbiter.sv
// Directed bench for dffrf_wport_arbiter with a behavioural register file behind it
// and a scoreboard of expected commit-stage contents.
module tb_dffrf_wport_arbiter;

    logic         CLK;
    logic         RST_N;
    logic [3:0]   REQ_VALID;
    logic [3:0]   REQ_READY;
    logic [19:0]  REQ_RW;
    logic [127:0] REQ_DW;
    logic         HOLD;
    logic [4:0]   RA, RB;
    logic [31:0]  DA, DB;
    logic [4:0]   RF_RA, RF_RB;
    logic [31:0]  RF_DA, RF_DB;
    logic [4:0]   RF_RW;
    logic [31:0]  RF_DW;
    logic         RF_WE;
    logic [1:0]   GNT_ID;

    typedef struct packed {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] dw;
    } commit_t;

    commit_t     sbq[$];
    logic [4:0]  reqRw [4];
    logic [31:0] reqDw [4];
    logic [31:0] rf [32] = '{default: 32'h0};
    int compared   = 0;
    int mismatched = 0;

    dffrf_wport_arbiter #(.WSIZE(32), .NREQ(4), .R0_ZERO(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_RW(REQ_RW), .REQ_DW(REQ_DW), .HOLD(HOLD),
        .RA(RA), .RB(RB), .DA(DA), .DB(DB),
        .RF_RA(RF_RA), .RF_RB(RF_RB), .RF_DA(RF_DA), .RF_DB(RF_DB),
        .RF_RW(RF_RW), .RF_DW(RF_DW), .RF_WE(RF_WE), .GNT_ID(GNT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file behind the arbiter; it has no reset, so a dropped commit stays unwritten.
    always @(posedge CLK) begin
        if (RF_WE) rf[RF_RW] <= RF_DW;
    end
    assign RF_DA = rf[RF_RA];
    assign RF_DB = rf[RF_RB];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [4:0] rw, input logic [31:0] dw);
        reqRw[i] = rw;
        reqDw[i] = dw;
        REQ_RW[i*5 +: 5]   = rw;
        REQ_DW[i*32 +: 32] = dw;
    endtask

    task automatic checkCommit();
        commit_t e;
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        checkOutput("rf_we", {31'b0, RF_WE}, {31'b0, e.we});
        if (e.we) begin
            checkOutput("rf_rw", {27'b0, RF_RW}, {27'b0, e.rw});
            checkOutput("rf_dw", RF_DW, e.dw);
        end
    endtask

    // One cycle: drive at the falling edge, check the grant, then check the commit stage a cycle later.
    task automatic applyStimulus(input logic [3:0] valid, input logic hold, input int expWin);
        commit_t e;
        logic [3:0] expReady;
        REQ_VALID = valid;
        HOLD      = hold;
        #1;
        expReady = (expWin < 0) ? 4'b0 : (4'b1 << expWin);
        checkOutput("req_ready", {28'b0, REQ_READY}, {28'b0, expReady});
        checkOutput("gnt_id", {30'b0, GNT_ID}, (expWin < 0) ? 32'd0 : expWin);
        e = '0;
        if (expWin >= 0 && reqRw[expWin] != 5'd0) begin
            e.we = 1'b1;
            e.rw = reqRw[expWin];
            e.dw = reqDw[expWin];
        end
        sbq.push_back(e);
        @(negedge CLK);
        checkCommit();
    endtask

    initial begin
        RST_N = 1'b0; HOLD = 1'b0; RA = '0; RB = '0;
        REQ_VALID = 4'hF; REQ_RW = '0; REQ_DW = '0;
        setReq(0, 5'd1, 32'h1111_1111);
        setReq(1, 5'd2, 32'h2222_2222);
        setReq(2, 5'd3, 32'h3333_3333);
        setReq(3, 5'd4, 32'h4444_4444);

        @(negedge CLK);
        checkOutput("rst_ready", {28'b0, REQ_READY}, 32'd0);
        checkOutput("rst_we", {31'b0, RF_WE}, 32'd0);
        checkOutput("rst_gnt", {30'b0, GNT_ID}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Round robin with everyone valid.
        applyStimulus(4'hF, 1'b0, 0);
        applyStimulus(4'hF, 1'b0, 1);
        applyStimulus(4'hF, 1'b0, 2);
        applyStimulus(4'hF, 1'b0, 3);
        applyStimulus(4'hF, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, -1);

        // Single write with bypass while the file still holds the old value.
        setReq(2, 5'd5, 32'hDEAD_BEEF);
        applyStimulus(4'b0100, 1'b0, 2);
        RA = 5'd5; RB = 5'd5;
        #1;
        checkOutput("rf_ra_pass", {27'b0, RF_RA}, 32'd5);
        checkOutput("rf_da_old", RF_DA, 32'h0);
        checkOutput("bypass_da", DA, 32'hDEAD_BEEF);
        checkOutput("bypass_db", DB, 32'hDEAD_BEEF);
        applyStimulus(4'h0, 1'b0, -1);
        checkOutput("rf_da_new", RF_DA, 32'hDEAD_BEEF);
        checkOutput("da_from_rf", DA, 32'hDEAD_BEEF);

        // Write to R0 is handshaken but dropped; R0 is never forwarded.
        setReq(1, 5'd0, 32'h1234_5678);
        applyStimulus(4'b0010, 1'b0, 1);
        RA = 5'd0;
        #1;
        checkOutput("r0_da", DA, 32'h0);
        checkOutput("r0_db_other", DB, 32'hDEAD_BEEF);

        // Fairness between requesters 0 and 3, then 1 joins.
        setReq(1, 5'd2, 32'h2222_2222);
        applyStimulus(4'b1000, 1'b0, 3);
        applyStimulus(4'b1001, 1'b0, 0);
        applyStimulus(4'b1001, 1'b0, 3);
        applyStimulus(4'b1001, 1'b0, 0);
        applyStimulus(4'b1001, 1'b0, 3);
        applyStimulus(4'b1001, 1'b0, 0);
        applyStimulus(4'b1011, 1'b0, 1);
        applyStimulus(4'b1001, 1'b0, 3);
        applyStimulus(4'b1001, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, -1);

        // HOLD blocks grants but the write accepted just before still commits.
        setReq(0, 5'd6, 32'hCAFE_F00D);
        applyStimulus(4'b0001, 1'b0, 0);
        RA = 5'd6;
        #1;
        checkOutput("hold_bypass", DA, 32'hCAFE_F00D);
        applyStimulus(4'b0011, 1'b1, -1);
        applyStimulus(4'b0011, 1'b1, -1);
        applyStimulus(4'b0011, 1'b1, -1);
        checkOutput("hold_committed", DA, 32'hCAFE_F00D);
        applyStimulus(4'b0011, 1'b0, 1);
        applyStimulus(4'h0, 1'b0, -1);

        // Asynchronous reset while a write sits in the commit stage.
        setReq(2, 5'd7, 32'hA5A5_A5A5);
        applyStimulus(4'b0100, 1'b0, 2);
        RA = 5'd7;
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_we_drop", {31'b0, RF_WE}, 32'd0);
        REQ_VALID = 4'hF;
        #1;
        checkOutput("async_ready", {28'b0, REQ_READY}, 32'd0);
        checkOutput("async_da", DA, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        sbq.delete();
        checkOutput("r7_not_written", RF_DA, 32'h0);
        applyStimulus(4'hF, 1'b0, 0);
        applyStimulus(4'h0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
